// File: rtl/simple_dut_pkg.sv
// rtl/simple_dut_pkg.sv - shared opcodes, constants and status layout for simple_dut_core
package simple_dut_pkg;

    typedef enum logic [3:0] {
        OP_PASS   = 4'd0,
        OP_ACC    = 4'd1,
        OP_CLR    = 4'd2,
        OP_XOR    = 4'd3,
        OP_POPCNT = 4'd4
    } opcode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } exec_state_e;

    localparam logic [31:0] ERR_RESULT = 32'hDEADBEEF;

    // Status byte layout: [7:4] echoed tag, [3:1] zero, [0] error.
    localparam int STATUS_W       = 8;
    localparam int STATUS_TAG_MSB = 7;
    localparam int STATUS_TAG_LSB = 4;
    localparam int STATUS_ERR_BIT = 0;

    // FIFO entry = {status, result}
    localparam int RESP_W = STATUS_W + 32;

    function automatic logic [31:0] popcount32(input logic [31:0] v);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/simple_dut_fifo.sv
// rtl/simple_dut_fifo.sv - response buffer, circular FIFO with occupancy counter
// Ports: clk, rst (sync active-low), push/push_data write side, pop/rd_data read
// side (rd_data is the current head), full, empty, count (occupancy).
module simple_dut_fifo
    import simple_dut_pkg::*;
#(
    parameter int WIDTH = RESP_W,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are only visible while count is non-zero.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/simple_dut_core.sv
// rtl/simple_dut_core.sv - request/response compute core with accumulator and response FIFO
// Ports: clk, rst (sync active-low); request: i_bitSignal1 valid, i_bit32Signal1
// operand, i_bit8Signal2 {tag, opcode}; response: o_bitSignal1 valid,
// i_bitSignal2 ready, o_bit32Signal1 result, o_bit8Signal2 status;
// o_bitSignal2 busy (requests not accepted).
module simple_dut_core
    import simple_dut_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_bitSignal1,
    input  logic        i_bitSignal2,
    input  logic [31:0] i_bit32Signal1,
    input  logic [7:0]  i_bit8Signal2,
    output logic        o_bitSignal1,
    output logic        o_bitSignal2,
    output logic [31:0] o_bit32Signal1,
    output logic [7:0]  o_bit8Signal2
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    exec_state_e       state_q, state_d;
    logic [3:0]        s1_op_q, s1_op_d;
    logic [3:0]        s1_tag_q, s1_tag_d;
    logic [31:0]       s1_opd_q, s1_opd_d;
    logic              s2_valid_q, s2_valid_d;
    logic [RESP_W-1:0] s2_data_q, s2_data_d;
    logic [31:0]       acc_q, acc_d;

    logic              accept;
    logic              exec_fire;
    logic [31:0]       exec_result;
    logic              exec_err;
    logic [7:0]        exec_status;
    logic [1:0]        inflight;
    logic [CNT_W:0]    occupancy;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [RESP_W-1:0] fifo_head;
    logic [CNT_W-1:0]  fifo_count;

    // Busy counts in-flight requests as already occupying FIFO slots, so the
    // FIFO can never be overrun by responses still in the pipeline.
    assign inflight     = {1'b0, state_q == ST_EXEC} + {1'b0, s2_valid_q};
    assign occupancy    = {1'b0, fifo_count} + (CNT_W + 1)'(inflight);
    assign o_bitSignal2 = (occupancy >= (CNT_W + 1)'(FIFO_DEPTH));
    assign accept       = i_bitSignal1 && !o_bitSignal2;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: EXEC holds exactly the request accepted on the previous edge.
    always_comb begin
        state_d = accept ? ST_EXEC : ST_IDLE;
    end

    // State outputs
    always_comb begin
        exec_fire = (state_q == ST_EXEC);
    end

    // Request capture and execute. Requests execute strictly one per cycle in
    // acceptance order, so acc_q is always current for the request being executed.
    always_comb begin
        s1_op_d     = accept ? i_bit8Signal2[3:0] : s1_op_q;
        s1_tag_d    = accept ? i_bit8Signal2[7:4] : s1_tag_q;
        s1_opd_d    = accept ? i_bit32Signal1     : s1_opd_q;

        acc_d       = acc_q;
        exec_err    = 1'b0;
        exec_result = '0;
        case (s1_op_q)
            OP_PASS:   exec_result = s1_opd_q;
            OP_ACC: begin
                exec_result = acc_q + s1_opd_q;
                if (exec_fire) acc_d = exec_result;
            end
            OP_CLR: begin
                exec_result = '0;
                if (exec_fire) acc_d = '0;
            end
            OP_XOR:    exec_result = acc_q ^ s1_opd_q;
            OP_POPCNT: exec_result = popcount32(s1_opd_q);
            default: begin
                exec_result = ERR_RESULT;
                exec_err    = 1'b1;
            end
        endcase

        exec_status                                = '0;
        exec_status[STATUS_TAG_MSB:STATUS_TAG_LSB] = s1_tag_q;
        exec_status[STATUS_ERR_BIT]                = exec_err;

        s2_valid_d = exec_fire;
        s2_data_d  = exec_fire ? {exec_status, exec_result} : s2_data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_op_q    <= '0;
            s1_tag_q   <= '0;
            s1_opd_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            acc_q      <= '0;
        end else begin
            s1_op_q    <= s1_op_d;
            s1_tag_q   <= s1_tag_d;
            s1_opd_q   <= s1_opd_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            acc_q      <= acc_d;
        end
    end

    assign fifo_push = s2_valid_q && (!fifo_full || fifo_pop);
    assign fifo_pop  = !fifo_empty && i_bitSignal2;

    simple_dut_fifo #(
        .WIDTH (RESP_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (s2_data_q),
        .pop       (fifo_pop),
        .rd_data   (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign o_bitSignal1   = !fifo_empty;
    assign o_bit32Signal1 = fifo_empty ? '0 : fifo_head[31:0];
    assign o_bit8Signal2  = fifo_empty ? '0 : fifo_head[RESP_W-1:32];

endmodule

// File: tb/tb_simple_dut_core.sv
// tb/tb_simple_dut_core.sv - scoreboard testbench for simple_dut_core
module tb_simple_dut_core;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready = 1'b0;
    logic [31:0] in_operand = '0;
    logic [7:0]  in_word = '0;
    logic        o_valid;
    logic        o_busy;
    logic [31:0] o_result;
    logic [7:0]  o_status;

    always #5 clk = ~clk;

    simple_dut_core #(.FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_bitSignal1   (in_valid),
        .i_bitSignal2   (in_ready),
        .i_bit32Signal1 (in_operand),
        .i_bit8Signal2  (in_word),
        .o_bitSignal1   (o_valid),
        .o_bitSignal2   (o_busy),
        .o_bit32Signal1 (o_result),
        .o_bit8Signal2  (o_status)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [39:0] exp_q[$];
    int          acc_cnt = 0;
    int          pop_cnt = 0;
    int          pop_base = 0;
    logic [31:0] m_acc = '0;
    int          stall_accepts;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        acc_cnt  = 0;
        pop_base = pop_cnt;
        m_acc    = '0;
    endtask

    // One cycle of stimulus, entered and left at posedge+1. fix=1 pushes a
    // constant expectation instead of the model's (the model acc still advances).
    task automatic issue(input bit v, input logic [3:0] op, input logic [3:0] tag,
                         input logic [31:0] opd, input bit rdy, input bit fix,
                         input logic [31:0] fres, input logic [7:0] fstat);
        bit          busy_m;
        logic [31:0] r;
        bit          e;
        in_valid   = v;
        in_ready   = rdy;
        in_word    = {tag, op};
        in_operand = opd;
        busy_m     = (acc_cnt - (pop_cnt - pop_base)) >= DEPTH;
        chk("busy", o_busy, busy_m);
        if (v && !busy_m) begin
            e = 1'b0;
            case (op)
                4'd0: r = opd;
                4'd1: begin m_acc = m_acc + opd; r = m_acc; end
                4'd2: begin m_acc = 32'd0; r = 32'd0; end
                4'd3: r = m_acc ^ opd;
                4'd4: r = 32'($countones(opd));
                default: begin r = 32'hDEADBEEF; e = 1'b1; end
            endcase
            if (fix) exp_q.push_back({fstat, fres});
            else     exp_q.push_back({tag, 3'b000, e, r});
            acc_cnt++;
        end
        tick();
    endtask

    task automatic idle(input bit rdy);
        issue(1'b0, 4'd0, 4'd0, 32'd0, rdy, 1'b0, 32'd0, 8'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) idle(1'b1);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        fork
            begin : monitor
                forever begin
                    @(negedge clk);
                    if (rst) begin
                        if (o_valid) begin
                            if (exp_q.size() == 0) begin
                                chk("unexpected_valid", o_valid, 1'b0);
                            end else begin
                                chk("head_result", o_result, exp_q[0][31:0]);
                                chk("head_status", o_status, exp_q[0][39:32]);
                                if (in_ready) void'(exp_q.pop_front());
                            end
                            if (in_ready) pop_cnt++;
                        end else begin
                            chk("idle_zero", {o_status, o_result}, 40'd0);
                        end
                    end
                end
            end
            begin : stimulus
                repeat (3) tick();
                chk("rst_valid", o_valid, 1'b0);
                chk("rst_busy", o_busy, 1'b0);
                chk("rst_result", o_result, 32'd0);
                chk("rst_status", o_status, 8'd0);
                model_reset();

                // PASS right after reset release, with latency check
                rst = 1'b1;
                issue(1'b1, 4'd0, 4'd3, 32'h12345678, 1'b1, 1'b1, 32'h12345678, 8'h30);
                chk("lat_e0", o_valid, 1'b0);
                idle(1'b1);
                chk("lat_e1", o_valid, 1'b0);
                idle(1'b1);
                chk("lat_e2", o_valid, 1'b1);
                chk("pass_result", o_result, 32'h12345678);
                chk("pass_status", o_status, 8'h30);
                drain();

                // Back-to-back ACC with wrap-around
                issue(1'b1, 4'd1, 4'd1, 32'd5, 1'b1, 1'b1, 32'd5, 8'h10);
                issue(1'b1, 4'd1, 4'd2, 32'hFFFFFFFE, 1'b1, 1'b1, 32'd3, 8'h20);
                // Illegal opcode, then XOR 0 proves acc is still 3
                issue(1'b1, 4'hF, 4'd2, 32'h0BAD0BAD, 1'b1, 1'b1, 32'hDEADBEEF, 8'h21);
                issue(1'b1, 4'd3, 4'd0, 32'd0, 1'b1, 1'b1, 32'd3, 8'h00);
                // POPCNT, CLR, ACC
                issue(1'b1, 4'd4, 4'd5, 32'hF0F0000F, 1'b1, 1'b1, 32'd12, 8'h50);
                issue(1'b1, 4'd2, 4'd6, 32'h55555555, 1'b1, 1'b1, 32'd0, 8'h60);
                issue(1'b1, 4'd1, 4'd7, 32'd7, 1'b1, 1'b1, 32'd7, 8'h70);
                drain();

                // Backpressure: continuous requests with no consumer
                stall_accepts = 0;
                for (int i = 0; i < 10; i++) begin
                    if (!o_busy) stall_accepts++;
                    issue(1'b1, 4'd0, 4'(i), $urandom, 1'b0, 1'b0, 32'd0, 8'd0);
                end
                chk("stall_accepts", 64'(stall_accepts), 64'd4);
                chk("stall_busy", o_busy, 1'b1);
                chk("stall_valid", o_valid, 1'b1);
                drain();

                // Reset with queued responses
                for (int i = 0; i < 3; i++) issue(1'b1, 4'd0, 4'(i + 8), $urandom, 1'b0, 1'b0, 32'd0, 8'd0);
                repeat (3) idle(1'b0);
                chk("pre_rst_valid", o_valid, 1'b1);
                rst      = 1'b0;
                in_valid = 1'b0;
                tick();
                chk("mid_rst_valid", o_valid, 1'b0);
                chk("mid_rst_busy", o_busy, 1'b0);
                chk("mid_rst_result", o_result, 32'd0);
                model_reset();
                rst = 1'b1;
                issue(1'b1, 4'd0, 4'd9, 32'hCAFEF00D, 1'b1, 1'b1, 32'hCAFEF00D, 8'h90);
                drain();

                // Randomized traffic
                for (int i = 0; i < 400; i++) begin
                    issue($urandom_range(0, 9) < 7, 4'($urandom_range(0, 7)) | ($urandom_range(0, 15) == 0 ? 4'h8 : 4'h0),
                          4'($urandom), ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0 + 32'($urandom_range(0, 15)) : $urandom,
                          $urandom_range(0, 9) < 6, 1'b0, 32'd0, 8'd0);
                end
                drain();
            end
        join_any
        disable fork;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/simple_dut_core.md
SIMPLE_DUT_CORE -- requirements
Module: simple_dut_core

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, giving the number of response FIFO entries; legal values are powers of two, 2 to 16.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port i_bitSignal1, input, 1 bit: request valid.
REQ-005 The block SHALL have port i_bitSignal2, input, 1 bit: response ready (consumer backpressure).
REQ-006 The block SHALL have port i_bit32Signal1, input, 32 bits: request operand.
REQ-007 The block SHALL have port i_bit8Signal2, input, 8 bits: request word, [7:4] tag and [3:0] opcode.
REQ-008 The block SHALL have port o_bitSignal1, output, 1 bit: response valid, meaning the FIFO is non-empty.
REQ-009 The block SHALL have port o_bitSignal2, output, 1 bit: busy, meaning requests are not accepted this cycle.
REQ-010 The block SHALL have port o_bit32Signal1, output, 32 bits: response result at the FIFO head.
REQ-011 The block SHALL have port o_bit8Signal2, output, 8 bits: response status at the FIFO head, [7:4] echoed tag, [3:1] zero, [0] error.

Function
REQ-012 A request SHALL be accepted in any cycle where i_bitSignal1=1 and o_bitSignal2=0; when o_bitSignal2=1 the request is ignored and has no side effects.
REQ-013 The opcode decode SHALL be as follows:
- 0 PASS: result = operand.
- 1 ACC: acc = acc + operand, mod 2^32; result = new acc.
- 2 CLR: acc = 0; result = 0.
- 3 XOR: result = acc ^ operand; acc unchanged.
- 4 POPCNT: result = number of ones in operand, zero-extended.
- Any other opcode: result = 32'hDEADBEEF, error=1, acc unchanged.
REQ-014 Each accepted request SHALL be registered in an execute stage (state machine IDLE/EXEC) and pushed into the FIFO exactly 2 cycles after acceptance; o_bitSignal1 rises no earlier than that edge.
REQ-015 Back-to-back requests on consecutive cycles SHALL be accepted at one per cycle, and their responses emerge in acceptance order.
REQ-016 A FIFO pop SHALL occur on a cycle where o_bitSignal1=1 and i_bitSignal2=1; head outputs hold stable while o_bitSignal1=1 and i_bitSignal2=0.
REQ-017 o_bitSignal2 SHALL be 1 when FIFO occupancy plus in-flight requests is at least FIFO_DEPTH, so that the FIFO never overflows.
REQ-018 A push and a pop in the same cycle SHALL leave occupancy unchanged and SHALL be legal when the FIFO is full or empty-with-push.
REQ-019 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; occupancy is tracked with a counter of width $clog2(FIFO_DEPTH)+1.
REQ-020 When o_bitSignal1=0, o_bit32Signal1 and o_bit8Signal2 SHALL be driven to 0.
REQ-021 An ACC request SHALL see the acc value updated by all earlier accepted requests, including one accepted in the immediately preceding cycle.

Reset
REQ-022 While rst=0 at a clock edge, the following SHALL hold on the next cycle:
- acc = 0, FIFO empty, in-flight stages cleared, state IDLE.
- o_bitSignal1 = 0, o_bitSignal2 = 0.
- o_bit32Signal1 = 0, o_bit8Signal2 = 0.
REQ-023 Reset asserted mid-operation SHALL discard all in-flight and queued responses with no partial output.
REQ-024 The first request SHALL be accepted in the first cycle after rst returns to 1.

Structure
REQ-025 A shared package simple_dut_pkg SHALL hold:
- the opcode enum;
- the ERR_RESULT constant 32'hDEADBEEF;
- the status field positions.
REQ-026 The response buffer SHALL be a sub-module simple_dut_fifo, parameterised by width (40) and FIFO_DEPTH, with push, pop, full, empty and count.

Verification
REQ-027 Reset release, then PASS of 32'h12345678 with tag 3 and i_bitSignal2=1 -> o_bitSignal1=1 two cycles after acceptance, o_bit32Signal1=32'h12345678, o_bit8Signal2=8'h30.
REQ-028 ACC of 5, then ACC of 32'hFFFFFFFE back-to-back -> results 5, then 3 (wrap-around), in order.
REQ-029 i_bitSignal2=0 with continuous requests -> exactly 4 responses queued, o_bitSignal2=1, further requests ignored; raising i_bitSignal2 drains 4 in order.
REQ-030 Opcode 4'hF with tag 2 -> result 32'hDEADBEEF, o_bit8Signal2=8'h21, acc unchanged (verified by a following XOR with 0).
REQ-031 POPCNT of 32'hF0F0000F -> result 12; then CLR -> result 0; then ACC of 7 -> result 7.
REQ-032 Assert rst=0 with 3 queued responses -> next cycle o_bitSignal1=0; after release, the first new response is the only one seen.
